// File: rtl/pool_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : pool_result_collector
// Purpose  : Deskews column-skewed pooling results into full output rows.
//            Each row is written as one wide word over a valid/ready port.
//            Row addresses run from a programmed base address.
// Options  : POOL_COLLECT_RELU_EN - clamp negative captured values to zero
// Revision : 1.0 - initial release
// ============================================================================
module pool_result_collector #(
   parameter int DATA_WIDTH = 16,
   parameter int COL        = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LANE_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic                      start,
   input  logic [ADDR_WIDTH-1:0]     base_addr,
   input  logic [ADDR_WIDTH-1:0]     num_rows,
   input  logic [COL*DATA_WIDTH-1:0] pool_data,
   input  logic [COL-1:0]            pool_done,
   output logic                      wr_valid,
   input  logic                      wr_ready,
   output logic [ADDR_WIDTH-1:0]     wr_addr,
   output logic [COL*DATA_WIDTH-1:0] wr_data,
   output logic                      busy,
   output logic                      done,
   output logic                      overflow
);

   localparam int PTR_W = $clog2(LANE_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]                state_q, state_d;
   logic [ADDR_WIDTH-1:0]     base_q, num_rows_q;
   logic [ADDR_WIDTH-1:0]     row_cnt_q, row_cnt_d;
   logic                      overflow_q, overflow_d;

   logic                      w_accept;
   logic                      w_pop;
   logic                      w_last_row;
   logic [COL-1:0]            w_lane_nempty;
   logic [COL-1:0]            w_lane_ovf;
   logic [COL*DATA_WIDTH-1:0] w_heads;

   assign w_accept   = (state_q == S_IDLE) && start;
   assign wr_valid   = (state_q == S_RUN) && (&w_lane_nempty);
   assign w_pop      = wr_valid && wr_ready;
   assign w_last_row = (row_cnt_q == (num_rows_q - ADDR_WIDTH'(1)));
   assign wr_addr    = base_q + row_cnt_q;
   // Gate the data so an idle port shows zeros rather than stale FIFO storage.
   assign wr_data    = wr_valid ? w_heads : '0;
   assign overflow   = overflow_q;

   // Per-lane deskew FIFOs: push in RUN, common pop on row handshake.
   generate
      for (genvar i = 0; i < COL; i++) begin : g_lane
         logic [DATA_WIDTH-1:0] mem_q [LANE_DEPTH];
         logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
         logic [CNT_W-1:0]      cnt_q;
         logic                  w_push, w_full, w_write;
         logic [DATA_WIDTH-1:0] w_cap;

         assign w_push  = (state_q == S_RUN) && pool_done[i];
         assign w_full  = (cnt_q == CNT_W'(LANE_DEPTH));
         // A full lane may still accept when the row pops in the same cycle.
         assign w_write = w_push && (!w_full || w_pop);

         assign w_lane_nempty[i] = (cnt_q != '0);
         assign w_lane_ovf[i]    = w_push && w_full && !w_pop;
         assign w_heads[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q];

         // Capture transform applied to the incoming lane value.
         always_comb begin
`ifdef POOL_COLLECT_RELU_EN
            w_cap = pool_data[i*DATA_WIDTH + DATA_WIDTH - 1] ?
                    '0 : pool_data[i*DATA_WIDTH +: DATA_WIDTH];
`else
            w_cap = pool_data[i*DATA_WIDTH +: DATA_WIDTH];
`endif
         end

         // Storage array; no reset needed since reads are gated by occupancy.
         always_ff @(posedge clk) begin
            if (w_write) begin
               mem_q[wr_ptr_q] <= w_cap;
            end
         end

         // Pointer and occupancy bookkeeping, flushed on an accepted start.
         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               cnt_q    <= '0;
            end else if (w_accept) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               cnt_q    <= '0;
            end else begin
               if (w_write) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
               if (w_pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
               if (w_write && !w_pop)      cnt_q <= cnt_q + CNT_W'(1);
               else if (w_pop && !w_write) cnt_q <= cnt_q - CNT_W'(1);
            end
         end
      end
   endgenerate

   // State register plus job-level registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         num_rows_q <= '0;
         row_cnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_cnt_q  <= row_cnt_d;
         overflow_q <= overflow_d;
         if (w_accept) begin
            base_q     <= base_addr;
            num_rows_q <= num_rows;
         end
      end
   end

   // Next-state and next-value logic for the job sequencer.
   always_comb begin
      state_d    = state_q;
      row_cnt_d  = row_cnt_q;
      overflow_d = overflow_q | (|w_lane_ovf);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               row_cnt_d  = '0;
               overflow_d = 1'b0;
               state_d    = (num_rows == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_pop) begin
               row_cnt_d = row_cnt_q + ADDR_WIDTH'(1);
               if (w_last_row) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_RUN:   busy = 1'b1;
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_pool_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_result_collector
// Purpose  : Self-checking bench for pool_result_collector with a write
//            scoreboard (expected rows queued at stimulus, popped on write).
// Options  : POOL_COLLECT_RELU_EN - selects the clamped expectation
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_result_collector;

   localparam int DW  = 16;
   localparam int COL = 32;
   localparam int AW  = 10;
   localparam int LD  = 4;
   localparam int W   = COL * DW;

   typedef struct {
      logic [AW-1:0] addr;
      logic [W-1:0]  data;
   } row_t;

   logic          clk = 1'b0;
   logic          nrst;
   logic          start;
   logic [AW-1:0] base_addr, num_rows;
   logic [W-1:0]  pool_data;
   logic [COL-1:0] pool_done;
   logic          wr_valid, wr_ready;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic          busy, done, overflow;

   row_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   n_writes = 0;
   int   n_done   = 0;

   pool_result_collector #(
      .DATA_WIDTH(DW), .COL(COL), .ADDR_WIDTH(AW), .LANE_DEPTH(LD)
   ) dut (
      .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr),
      .num_rows(num_rows), .pool_data(pool_data), .pool_done(pool_done),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] cap(input logic [DW-1:0] v);
`ifdef POOL_COLLECT_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   // Row whose lane i holds base + i (bench-side expected data).
   function automatic logic [W-1:0] make_row(input int base);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < COL; i++) r[i*DW +: DW] = cap(DW'(base + i));
      return r;
   endfunction

   // Inputs are stable from here until the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
      start = 1'b1; base_addr = b; num_rows = n;
      tick();
      start = 1'b0;
   endtask

   task automatic push_row(input int base);
      pool_done = '1;
      for (int i = 0; i < COL; i++) pool_data[i*DW +: DW] = DW'(base + i);
      tick();
      pool_done = '0;
   endtask

   task automatic wait_done(input int budget);
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("done_reached", {511'b0, done}, 1);
      tick();
      chk("idle_after_done", {510'b0, busy, done}, 0);
   endtask

   task automatic expect_row(input logic [AW-1:0] a, input logic [W-1:0] d);
      row_t e;
      e.addr = a; e.data = d;
      sb.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wr_valid"}, {511'b0, wr_valid}, 0);
      chk({tag, "_wr_addr"},  W'(wr_addr), 0);
      chk({tag, "_wr_data"},  wr_data, 0);
      chk({tag, "_busy"},     {511'b0, busy}, 0);
      chk({tag, "_done"},     {511'b0, done}, 0);
      chk({tag, "_overflow"}, {511'b0, overflow}, 0);
   endtask

   // Write monitor: a handshake seen here completes on the next rising edge.
   always @(negedge clk) begin
      if (nrst && done) n_done++;
      if (nrst && wr_valid && wr_ready) begin
         n_writes++;
         chk("write_expected", {511'b0, (sb.size() != 0)}, 1);
         if (sb.size() != 0) begin
            row_t e;
            e = sb.pop_front();
            chk("wr_addr", W'(wr_addr), W'(e.addr));
            chk("wr_data", wr_data, e.data);
         end
      end
   end

   initial begin
      int wbase, dbase;
      logic [W-1:0] exp_row;

      nrst = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
      pool_data = '0; pool_done = '0; wr_ready = 1'b0;
      tick();
      check_reset_outputs("reset");
      tick();
      nrst = 1'b1;
      tick();

      // Skewed stream: lane i pushes row r at cycle r+i.
      wr_ready = 1'b1;
      dbase = n_done;
      for (int r = 0; r < 3; r++) expect_row(AW'(10'h10 + r), make_row(r * 100));
      do_start(10'h10, 10'd3);
      chk("busy_after_start", {511'b0, busy}, 1);
      for (int t = 0; t < 3 + COL - 1; t++) begin
         pool_done = '0;
         for (int i = 0; i < COL; i++) begin
            if (t - i >= 0 && t - i < 3) begin
               pool_done[i] = 1'b1;
               pool_data[i*DW +: DW] = DW'((t - i) * 100 + i);
            end
         end
         tick();
      end
      pool_done = '0;
      wait_done(20);
      chk("skew_drained", W'(sb.size()), 0);
      chk("skew_done_once", W'(n_done - dbase), 1);
      chk("skew_overflow", {511'b0, overflow}, 0);

      // Backpressure: row held stable while wr_ready is low.
      wr_ready = 1'b0;
      do_start(10'h20, 10'd1);
      push_row(16'h1234);
      exp_row = make_row(16'h1234);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", {511'b0, wr_valid}, 1);
         chk("bp_addr", W'(wr_addr), W'(10'h20));
         chk("bp_data", wr_data, exp_row);
         tick();
      end
      wbase = n_writes;
      expect_row(10'h20, exp_row);
      wr_ready = 1'b1;
      wait_done(10);
      chk("bp_single_write", W'(n_writes - wbase), 1);

      // Overflow: five pushes into lane 0 of depth four.
      wr_ready = 1'b0;
      do_start(10'h000, 10'd1);
      for (int k = 0; k < LD + 1; k++) begin
         pool_done = '0; pool_done[0] = 1'b1;
         pool_data[0 +: DW] = DW'(16'h100 + k);
         tick();
         if (k == LD - 1) chk("ovf_not_yet", {511'b0, overflow}, 0);
      end
      chk("ovf_set", {511'b0, overflow}, 1);
      pool_done = '1; pool_done[0] = 1'b0;
      for (int i = 1; i < COL; i++) pool_data[i*DW +: DW] = DW'(16'h700 + i);
      tick();
      pool_done = '0;
      exp_row = make_row(16'h700);
      exp_row[0 +: DW] = cap(16'h100);
      expect_row(10'h000, exp_row);
      wr_ready = 1'b1;
      wait_done(10);
      chk("ovf_sticky", {511'b0, overflow}, 1);

      // Wrap: addresses 0x3FF then 0x000; overflow cleared by the start.
      expect_row(10'h3FF, make_row(16'h2000));
      expect_row(10'h000, make_row(16'h3000));
      do_start(10'h3FF, 10'd2);
      chk("ovf_cleared", {511'b0, overflow}, 0);
      push_row(16'h2000);
      push_row(16'h3000);
      wait_done(10);
      chk("wrap_drained", W'(sb.size()), 0);

      // Zero-row job: done right after start, nothing written.
      wbase = n_writes;
      do_start(10'h055, 10'd0);
      chk("zero_done", {510'b0, busy, done}, 2'b01);
      tick();
      chk("zero_no_write", W'(n_writes - wbase), 0);

      // Reset mid-job after one row, with two lanes partly filled.
      wbase = n_writes;
      expect_row(10'h040, make_row(16'h4000));
      do_start(10'h040, 10'd3);
      push_row(16'h4000);
      tick();
      chk("mid_one_write", W'(n_writes - wbase), 1);
      pool_done = '0; pool_done[1:0] = 2'b11;
      pool_data[0 +: 2*DW] = {16'h0BAD, 16'h0BAD};
      tick();
      pool_done = '0;
      nrst = 1'b0;
      #1;
      check_reset_outputs("midreset");
      tick();
      tick();
      nrst = 1'b1;
      tick();
      expect_row(10'h080, make_row(16'h5000));
      do_start(10'h080, 10'd1);
      push_row(16'h5000);
      wait_done(10);
      chk("fresh_drained", W'(sb.size()), 0);

      // Negative value on lane 3.
      exp_row = make_row(16'h0);
      exp_row[3*DW +: DW] = cap(16'hFFF0);
      expect_row(10'h050, exp_row);
      do_start(10'h050, 10'd1);
      pool_done = '1;
      for (int i = 0; i < COL; i++) pool_data[i*DW +: DW] = DW'(i);
      pool_data[3*DW +: DW] = 16'hFFF0;
      tick();
      pool_done = '0;
      wait_done(10);
      chk("final_drained", W'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
